id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection, stall/flush handling and a bubble counter.
//  Captures decoded operands and control from ID and presents them to EX, where ALUOp/Funct7/Funct3 feed
//  the ALU controller and the operands feed the ALU. Generates the IF/ID hold signal on load-use hazards.
// PARAMETERS
//  XLEN       32  datapath width (PC, operands, immediate)
//  RADDR_W    5   register-file address width
//  CNT_W      32  width of the bubble performance counter
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        synchronous, active-high reset
//  id_valid       in   1        ID holds a real instruction
//  id_pc          in   XLEN     PC of ID instruction
//  id_rd1/id_rd2  in   XLEN     register-file read data
//  id_imm         in   XLEN     sign-extended immediate
//  id_rs1/id_rs2  in   RADDR_W  source register indices
//  id_rs2_used    in   1        instruction reads rs2 (R/S/B types)
//  id_rd          in   RADDR_W  destination register index
//  id_funct3      in   3        instr[14:12]
//  id_funct7      in   7        instr[31:25]
//  id_alu_op      in   2        ALUOp from main decoder
//  id_ctrl        in   ctrl_t   {alu_src,mem_read,mem_write,mem_to_reg,reg_write,branch}
//  flush          in   1        EX redirect (taken branch/jump); kill ID instruction
//  ex_valid       out  1        EX holds a real instruction
//  ex_pc, ex_rd1, ex_rd2, ex_imm  out XLEN  registered copies
//  ex_rs1/ex_rs2/ex_rd out RADDR_W registered copies (forwarding unit uses rs1/rs2)
//  ex_funct3 out 3; ex_funct7 out 7; ex_alu_op out 2; ex_ctrl out ctrl_t  registered copies
//  stall          out  1        combinational; hold PC and IF/ID this cycle
//  bubble_cnt     out  CNT_W    bubbles inserted since reset (saturating)
// BEHAVIOUR
//  Reset (sync): every registered output = 0; ex_valid=0; bubble_cnt=0. stall is 0 while ex_valid=0.
//  Hazard (comb): stall = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd!=0) &
//    ((ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)) & ~flush.
//  Per rising edge, priority reset > flush > stall > load:
//   - flush: insert bubble; stall output forced 0 (flush overrides hazard).
//   - stall: insert bubble; IF/ID holds, so the same ID instruction is re-presented next cycle.
//   - load: all ex_* <= id_*; ex_valid <= id_valid. id_valid=0 loads an all-zero bubble.
//  Bubble = ex_valid=0, ex_ctrl=0, ex_alu_op=2'b00, ex_funct3=0, ex_funct7=0, all data/index fields 0.
//   Zeroed funct/ALUOp gives the ALU controller a deterministic input; reg_write/mem_write=0 gives no side effects.
//  Latency: 1 cycle ID->EX. Load-use costs exactly 1 bubble; next cycle EX holds the bubble, so stall deasserts.
//  bubble_cnt increments by 1 on every edge that inserts a bubble due to flush or stall (not id_valid=0).
//   Holds at all-ones.
//  x0 rule: ex_rd==0 never triggers stall, even for a load to x0.
//  Reset asserted during a stall: reset wins; next cycle ex_valid=0, stall=0.
// STRUCTURE
//  Package riscv_pkg: ctrl_t packed struct, ALU_OP_* localparams (00 load/store, 01 branch, 10 R-type),
//   and BUBBLE_CTRL constant ('0).
//  Sub-module hazard_detect (pure comb: id_rs1/id_rs2/id_rs2_used/id_valid, ex_rd/ex_mem_read/ex_valid,
//   flush -> stall). Register bank and counter live in id_ex_stage_reg.
// TESTING
//  1 Reset: hold reset 2 cycles with random ID inputs -> all ex_* = 0, stall=0, bubble_cnt=0.
//  2 Pass-through: id add x3,x1,x2 (funct3=000, funct7=0, alu_op=10, rd1=5, rd2=7) -> next cycle
//    ex_* match, ex_valid=1, stall=0.
//  3 Load-use: EX=lw x5 (mem_read=1, rd=5); ID=add x6,x5,x1 -> stall=1. Next edge: bubble, bubble_cnt=1.
//    Following cycle: stall=0, add loads.
//  4 No false stall: EX=lw x0; ID uses x0 -> stall=0. EX=lw x5; ID=addi rs2=5, rs2_used=0 -> stall=0.
//  5 Flush vs stall: load-use condition plus flush=1 -> stall=0; bubble inserted; bubble_cnt increments once.
//  6 Saturation: preload CNT_W=4 variant to 15, force a flush -> bubble_cnt stays 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//  Shared types and constants for the ID/EX stage.
//  - ctrl_t       : main-decoder control bundle carried from ID into EX
//  - ALU_OP_*     : ALUOp encodings presented to the ALU controller
//  - BUBBLE_CTRL  : control value of a bubble (no side effects)
// ---------------------------------------------------------------------------
package riscv_pkg;

   typedef struct packed {
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
      logic branch;
   } ctrl_t;

   localparam logic [1:0] ALU_OP_LDST   = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

   localparam ctrl_t BUBBLE_CTRL = '0;

endpackage : riscv_pkg

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//  Purely combinational load-use hazard detector.
//  Inputs : id_valid, id_rs1, id_rs2, id_rs2_used  (instruction in ID)
//           ex_valid, ex_mem_read, ex_rd           (instruction in EX)
//           flush                                   (EX redirect)
//  Output : stall  - hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module hazard_detect #(
   parameter int RADDR_W = 5
) (
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic               id_rs2_used,
   input  logic               ex_valid,
   input  logic               ex_mem_read,
   input  logic [RADDR_W-1:0] ex_rd,
   input  logic               flush,
   output logic               stall
);

   logic rd_nonzero;
   logic rs1_match;
   logic rs2_match;

   // Load in EX whose destination is read by ID; x0 is never a real producer,
   // and a flush kills the ID instruction so no stall is needed.
   always_comb begin
      rd_nonzero = (ex_rd != '0);
      rs1_match  = (ex_rd == id_rs1);
      rs2_match  = id_rs2_used & (ex_rd == id_rs2);
      stall      = id_valid & ex_valid & ex_mem_read & rd_nonzero &
                   (rs1_match | rs2_match) & ~flush;
   end

endmodule : hazard_detect

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//  ID/EX pipeline register with load-use stall, flush and a saturating
//  bubble counter.
//  Inputs : clk, reset (sync, active-high), id_* (decoded instruction),
//           flush (EX redirect)
//  Outputs: ex_* (registered copies of id_*), ex_valid,
//           stall (combinational IF/ID hold), bubble_cnt
//  Edge priority: reset > flush > stall > load. Flush, stall and an invalid
//  ID instruction all load an all-zero bubble; only flush/stall are counted.
// ---------------------------------------------------------------------------
module id_ex_stage_reg
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rd1,
   input  logic [XLEN-1:0]    id_rd2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic               id_rs2_used,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [2:0]         id_funct3,
   input  logic [6:0]         id_funct7,
   input  logic [1:0]         id_alu_op,
   input  ctrl_t              id_ctrl,
   input  logic               flush,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_rd1,
   output logic [XLEN-1:0]    ex_rd2,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_rs1,
   output logic [RADDR_W-1:0] ex_rs2,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [2:0]         ex_funct3,
   output logic [6:0]         ex_funct7,
   output logic [1:0]         ex_alu_op,
   output ctrl_t              ex_ctrl,
   output logic               stall,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic               valid_q,  valid_d;
   logic [XLEN-1:0]    pc_q,     pc_d;
   logic [XLEN-1:0]    rd1_q,    rd1_d;
   logic [XLEN-1:0]    rd2_q,    rd2_d;
   logic [XLEN-1:0]    imm_q,    imm_d;
   logic [RADDR_W-1:0] rs1_q,    rs1_d;
   logic [RADDR_W-1:0] rs2_q,    rs2_d;
   logic [RADDR_W-1:0] rd_q,     rd_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [6:0]         funct7_q, funct7_d;
   logic [1:0]         alu_op_q, alu_op_d;
   ctrl_t              ctrl_q,   ctrl_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;

   logic stall_s;
   logic bubble_s;
   logic count_s;

   hazard_detect #(
      .RADDR_W (RADDR_W)
   ) u_hazard (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs2_used (id_rs2_used),
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .flush       (flush),
      .stall       (stall_s)
   );

   // Next-state selection: bubble (flush/stall/invalid ID) or ID payload;
   // counter advances on flush/stall bubbles and saturates at all-ones.
   always_comb begin
      count_s  = flush | stall_s;
      bubble_s = count_s | ~id_valid;

      if (bubble_s) begin
         valid_d  = 1'b0;
         pc_d     = '0;
         rd1_d    = '0;
         rd2_d    = '0;
         imm_d    = '0;
         rs1_d    = '0;
         rs2_d    = '0;
         rd_d     = '0;
         funct3_d = 3'b000;
         funct7_d = 7'b0000000;
         alu_op_d = ALU_OP_LDST;
         ctrl_d   = BUBBLE_CTRL;
      end else begin
         valid_d  = 1'b1;
         pc_d     = id_pc;
         rd1_d    = id_rd1;
         rd2_d    = id_rd2;
         imm_d    = id_imm;
         rs1_d    = id_rs1;
         rs2_d    = id_rs2;
         rd_d     = id_rd;
         funct3_d = id_funct3;
         funct7_d = id_funct7;
         alu_op_d = id_alu_op;
         ctrl_d   = id_ctrl;
      end

      if (count_s && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // ID/EX register bank and bubble counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         imm_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         funct3_q <= 3'b000;
         funct7_q <= 7'b0000000;
         alu_op_q <= 2'b00;
         ctrl_q   <= BUBBLE_CTRL;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         imm_q    <= imm_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         funct3_q <= funct3_d;
         funct7_q <= funct7_d;
         alu_op_q <= alu_op_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_pc      = pc_q;
   assign ex_rd1     = rd1_q;
   assign ex_rd2     = rd2_q;
   assign ex_imm     = imm_q;
   assign ex_rs1     = rs1_q;
   assign ex_rs2     = rs2_q;
   assign ex_rd      = rd_q;
   assign ex_funct3  = funct3_q;
   assign ex_funct7  = funct7_q;
   assign ex_alu_op  = alu_op_q;
   assign ex_ctrl    = ctrl_q;
   assign stall      = stall_s;
   assign bubble_cnt = cnt_q;

endmodule : id_ex_stage_reg
